// File: rtl/call_stack_pc_pkg.sv
// ---------------------------------------------------------------------------
// call_stack_pc_pkg
// Shared definitions for the call_stack_pc program counter:
//   action_t             - the single action selected each cycle
//   DEFAULT_*            - default parameter values
//   select_action()      - request priority resolution (Stall > Load > Call >
//                          Return > Offset > increment)
// ---------------------------------------------------------------------------
package call_stack_pc_pkg;

    typedef enum logic [2:0] {
        ACT_HOLD,
        ACT_LOAD,
        ACT_CALL,
        ACT_RET,
        ACT_OFFSET,
        ACT_INC
    } action_t;

    localparam int DEFAULT_WIDTH        = 16;
    localparam int DEFAULT_OFFSET_WIDTH = 9;
    localparam int DEFAULT_STACK_DEPTH  = 8;

    // Reset is handled by the registers themselves; this only ranks the
    // functional requests so that exactly one of them takes effect.
    function automatic action_t select_action(input logic stall,
                                              input logic load,
                                              input logic call,
                                              input logic ret,
                                              input logic offset);
        if (stall)       return ACT_HOLD;
        else if (load)   return ACT_LOAD;
        else if (call)   return ACT_CALL;
        else if (ret)    return ACT_RET;
        else if (offset) return ACT_OFFSET;
        else             return ACT_INC;
    endfunction

endpackage

// File: rtl/lifo_stack.sv
// ---------------------------------------------------------------------------
// lifo_stack
// Return-address storage for call_stack_pc: a STACK_DEPTH-entry LIFO.
//   Clock, Reset  - rising-edge clock, synchronous active-high reset
//                   (clears the occupancy count only; storage is not cleared)
//   push_i        - push push_data_i (ignored when full)
//   pop_i         - discard the top entry (ignored when empty)
//   push_data_i   - value to push
//   top_o         - current top entry (meaningful only when not empty)
//   count_o       - occupied entries, registered
//   full_o        - count_o == STACK_DEPTH
//   empty_o       - count_o == 0
// ---------------------------------------------------------------------------
module lifo_stack #(
    parameter int WIDTH       = 16,
    parameter int STACK_DEPTH = 8
) (
    input  logic                             Clock,
    input  logic                             Reset,
    input  logic                             push_i,
    input  logic                             pop_i,
    input  logic [WIDTH-1:0]                 push_data_i,
    output logic [WIDTH-1:0]                 top_o,
    output logic [$clog2(STACK_DEPTH+1)-1:0] count_o,
    output logic                             full_o,
    output logic                             empty_o
);

    localparam int CW = $clog2(STACK_DEPTH + 1);
    localparam int AW = $clog2(STACK_DEPTH);

    logic [WIDTH-1:0] mem_q [STACK_DEPTH];
    logic [CW-1:0]    count_q, count_d;
    logic [CW-1:0]    top_idx;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CW'(STACK_DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // The count doubles as the write pointer; the top sits one below it.
    assign top_idx = count_q - CW'(1);
    assign top_o   = mem_q[top_idx[AW-1:0]];
    assign count_o = count_q;

    always_comb begin
        count_d = count_q;
        if (do_push)
            count_d = count_q + CW'(1);
        else if (do_pop)
            count_d = count_q - CW'(1);
    end

    always_ff @(posedge Clock) begin
        if (Reset)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    always_ff @(posedge Clock) begin
        if (do_push)
            mem_q[count_q[AW-1:0]] <= push_data_i;
    end

endmodule

// File: rtl/call_stack_pc.sv
// ---------------------------------------------------------------------------
// call_stack_pc
// Program counter with absolute load, relative branch, and a hardware
// call/return stack.
//   Clock, Reset     - rising-edge clock, synchronous active-high reset
//   Stall            - hold every piece of state this cycle
//   LoadEnable/Value - absolute jump
//   CallEnable/Target- push CounterValue+1, jump to CallTarget
//   ReturnEnable     - jump to popped return address
//   OffsetEnable/Offset - CounterValue += sign-extended Offset
//   CounterValue     - registered program counter
//   StackCount       - occupied return-stack entries
//   StackOverflow    - sticky, call while full
//   StackUnderflow   - sticky, return while empty
// Optional feature macro: CALL_STACK_PC_ERR_FLAGS_EN. When undefined the two
// flag outputs are tied to 0; overflow/underflow still fall back to +1.
// ---------------------------------------------------------------------------
module call_stack_pc
    import call_stack_pc_pkg::*;
#(
    parameter int WIDTH        = DEFAULT_WIDTH,
    parameter int OFFSET_WIDTH = DEFAULT_OFFSET_WIDTH,
    parameter int STACK_DEPTH  = DEFAULT_STACK_DEPTH
) (
    input  logic                             Clock,
    input  logic                             Reset,
    input  logic                             Stall,
    input  logic                             LoadEnable,
    input  logic [WIDTH-1:0]                 LoadValue,
    input  logic                             OffsetEnable,
    input  logic [OFFSET_WIDTH-1:0]          Offset,
    input  logic                             CallEnable,
    input  logic [WIDTH-1:0]                 CallTarget,
    input  logic                             ReturnEnable,
    output logic [WIDTH-1:0]                 CounterValue,
    output logic [$clog2(STACK_DEPTH+1)-1:0] StackCount,
    output logic                             StackOverflow,
    output logic                             StackUnderflow
);

    action_t          act;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] pc_inc;
    logic [WIDTH-1:0] off_ext;
    logic [WIDTH-1:0] stack_top;
    logic             stack_full, stack_empty;
    logic             push, pop;

    assign act     = select_action(Stall, LoadEnable, CallEnable,
                                   ReturnEnable, OffsetEnable);
    assign pc_inc  = pc_q + WIDTH'(1);
    assign off_ext = WIDTH'($signed(Offset));

    // Only the winning action may touch the stack, so a masked Call or
    // Return never pushes or pops.
    assign push = (act == ACT_CALL);
    assign pop  = (act == ACT_RET);

    lifo_stack #(
        .WIDTH       (WIDTH),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_stack (
        .Clock       (Clock),
        .Reset       (Reset),
        .push_i      (push),
        .pop_i       (pop),
        .push_data_i (pc_inc),
        .top_o       (stack_top),
        .count_o     (StackCount),
        .full_o      (stack_full),
        .empty_o     (stack_empty)
    );

    always_comb begin
        pc_d = pc_q;
        unique case (act)
            ACT_HOLD:   pc_d = pc_q;
            ACT_LOAD:   pc_d = LoadValue;
            ACT_CALL:   pc_d = stack_full  ? pc_inc : CallTarget;
            ACT_RET:    pc_d = stack_empty ? pc_inc : stack_top;
            ACT_OFFSET: pc_d = pc_q + off_ext;
            ACT_INC:    pc_d = pc_inc;
            default:    pc_d = pc_q;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset)
            pc_q <= '0;
        else
            pc_q <= pc_d;
    end

    assign CounterValue = pc_q;

`ifdef CALL_STACK_PC_ERR_FLAGS_EN
    logic ovf_q, unf_q;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (act == ACT_CALL && stack_full)
                ovf_q <= 1'b1;
            if (act == ACT_RET && stack_empty)
                unf_q <= 1'b1;
        end
    end

    assign StackOverflow  = ovf_q;
    assign StackUnderflow = unf_q;
`else
    assign StackOverflow  = 1'b0;
    assign StackUnderflow = 1'b0;
`endif

endmodule

// File: tb/tb_call_stack_pc.sv
// ---------------------------------------------------------------------------
// tb_call_stack_pc
// Self-checking bench for call_stack_pc (default parameters). Directed
// scenarios plus randomized traffic against a queue-based reference model.
// Flag expectations follow CALL_STACK_PC_ERR_FLAGS_EN.
// ---------------------------------------------------------------------------
module tb_call_stack_pc;

`ifdef CALL_STACK_PC_ERR_FLAGS_EN
    localparam bit FLAGS_EN = 1'b1;
`else
    localparam bit FLAGS_EN = 1'b0;
`endif
    localparam int DEPTH = 8;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic        Stall = 1'b0;
    logic        LoadEnable = 1'b0;
    logic [15:0] LoadValue = '0;
    logic        OffsetEnable = 1'b0;
    logic [8:0]  Offset = '0;
    logic        CallEnable = 1'b0;
    logic [15:0] CallTarget = '0;
    logic        ReturnEnable = 1'b0;
    logic [15:0] CounterValue;
    logic [3:0]  StackCount;
    logic        StackOverflow;
    logic        StackUnderflow;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic [15:0] m_pc = '0;
    logic [15:0] m_stack[$];
    bit          m_ovf = 1'b0;
    bit          m_unf = 1'b0;

    call_stack_pc dut (
        .Clock          (Clock),
        .Reset          (Reset),
        .Stall          (Stall),
        .LoadEnable     (LoadEnable),
        .LoadValue      (LoadValue),
        .OffsetEnable   (OffsetEnable),
        .Offset         (Offset),
        .CallEnable     (CallEnable),
        .CallTarget     (CallTarget),
        .ReturnEnable   (ReturnEnable),
        .CounterValue   (CounterValue),
        .StackCount     (StackCount),
        .StackOverflow  (StackOverflow),
        .StackUnderflow (StackUnderflow)
    );

    always #5 Clock = ~Clock;

    // Apply one cycle of inputs, clock it, advance the model, settle.
    task automatic cycle(input bit rst, input bit stall, input bit ld,
                         input logic [15:0] ldv, input bit call,
                         input logic [15:0] tgt, input bit ret,
                         input bit off_en, input logic [8:0] off);
        Reset = rst; Stall = stall; LoadEnable = ld; LoadValue = ldv;
        CallEnable = call; CallTarget = tgt; ReturnEnable = ret;
        OffsetEnable = off_en; Offset = off;
        @(posedge Clock);
        if (rst) begin
            m_pc = '0; m_stack.delete(); m_ovf = 0; m_unf = 0;
        end else if (stall) begin
            // nothing changes
        end else if (ld) begin
            m_pc = ldv;
        end else if (call) begin
            if (m_stack.size() < DEPTH) begin
                m_stack.push_back(m_pc + 16'd1);
                m_pc = tgt;
            end else begin
                m_pc = m_pc + 16'd1;
                m_ovf = 1;
            end
        end else if (ret) begin
            if (m_stack.size() > 0) m_pc = m_stack.pop_back();
            else begin
                m_pc = m_pc + 16'd1;
                m_unf = 1;
            end
        end else if (off_en) begin
            m_pc = m_pc + 16'($signed(off));
        end else begin
            m_pc = m_pc + 16'd1;
        end
        #1;
    endtask

    task automatic idle();
        cycle(0, 0, 0, '0, 0, '0, 0, 0, '0);
    endtask

    task automatic test_reset();
        cycle(1, 0, 0, '0, 0, '0, 0, 0, '0);
        n_cmp++;
        if (CounterValue !== 16'h0000) begin
            n_err++; $display("FAIL reset_pc: got %h want 0000", CounterValue);
        end
        n_cmp++;
        if (StackCount !== 4'd0) begin
            n_err++; $display("FAIL reset_count: got %0d want 0", StackCount);
        end
        n_cmp++;
        if ({StackOverflow, StackUnderflow} !== 2'b00) begin
            n_err++; $display("FAIL reset_flags: got %b want 00", {StackOverflow, StackUnderflow});
        end
    endtask

    task automatic test_increment();
        for (int i = 1; i <= 5; i++) begin
            idle();
            n_cmp++;
            if (CounterValue !== 16'(i) || StackCount !== 4'd0) begin
                n_err++;
                $display("FAIL idle_inc[%0d]: got pc %h cnt %0d want pc %h cnt 0", i, CounterValue, StackCount, 16'(i));
            end
        end
    endtask

    task automatic test_call_return();
        cycle(0, 0, 1, 16'h0010, 0, '0, 0, 0, '0);
        cycle(0, 0, 0, '0, 1, 16'h0200, 0, 0, '0);
        n_cmp++;
        if (CounterValue !== 16'h0200 || StackCount !== 4'd1) begin
            n_err++; $display("FAIL call: got pc %h cnt %0d want pc 0200 cnt 1", CounterValue, StackCount);
        end
        for (int i = 1; i <= 3; i++) begin
            idle();
            n_cmp++;
            if (CounterValue !== 16'h0200 + 16'(i)) begin
                n_err++; $display("FAIL call_body[%0d]: got %h want %h", i, CounterValue, 16'h0200 + 16'(i));
            end
        end
        cycle(0, 0, 0, '0, 0, '0, 1, 0, '0);
        n_cmp++;
        if (CounterValue !== 16'h0011 || StackCount !== 4'd0) begin
            n_err++; $display("FAIL return: got pc %h cnt %0d want pc 0011 cnt 0", CounterValue, StackCount);
        end
    endtask

    task automatic test_overflow();
        logic [15:0] want;
        cycle(1, 0, 0, '0, 0, '0, 0, 0, '0);
        for (int i = 0; i < 9; i++)
            cycle(0, 0, 0, '0, 1, 16'h0100 + 16'(i * 16), 0, 0, '0);
        n_cmp++;
        if (CounterValue !== 16'h0171 || StackCount !== 4'd8) begin
            n_err++; $display("FAIL overflow_call: got pc %h cnt %0d want pc 0171 cnt 8", CounterValue, StackCount);
        end
        n_cmp++;
        if (StackOverflow !== FLAGS_EN) begin
            n_err++; $display("FAIL overflow_flag: got %b want %b", StackOverflow, FLAGS_EN);
        end
        for (int i = 0; i < 8; i++) begin
            cycle(0, 0, 0, '0, 0, '0, 1, 0, '0);
            want = (i < 7) ? 16'h0161 - 16'(i * 16) : 16'h0001;
            n_cmp++;
            if (CounterValue !== want || StackCount !== 4'(7 - i)) begin
                n_err++;
                $display("FAIL unwind[%0d]: got pc %h cnt %0d want pc %h cnt %0d", i, CounterValue, StackCount, want, 7 - i);
            end
        end
        n_cmp++;
        if (StackOverflow !== FLAGS_EN) begin
            n_err++; $display("FAIL overflow_sticky: got %b want %b", StackOverflow, FLAGS_EN);
        end
    endtask

    task automatic test_underflow_offset_wrap();
        cycle(1, 0, 0, '0, 0, '0, 0, 0, '0);
        cycle(0, 0, 1, 16'h0005, 0, '0, 0, 0, '0);
        cycle(0, 0, 0, '0, 0, '0, 1, 0, '0);
        n_cmp++;
        if (CounterValue !== 16'h0006 || StackCount !== 4'd0) begin
            n_err++; $display("FAIL underflow_ret: got pc %h cnt %0d want pc 0006 cnt 0", CounterValue, StackCount);
        end
        n_cmp++;
        if (StackUnderflow !== FLAGS_EN) begin
            n_err++; $display("FAIL underflow_flag: got %b want %b", StackUnderflow, FLAGS_EN);
        end
        cycle(0, 0, 1, 16'h0004, 0, '0, 0, 0, '0);
        cycle(0, 0, 0, '0, 0, '0, 0, 1, 9'h100);
        n_cmp++;
        if (CounterValue !== 16'hFF04) begin
            n_err++; $display("FAIL offset_neg: got %h want ff04", CounterValue);
        end
        cycle(0, 0, 0, '0, 0, '0, 0, 1, 9'h0FF);
        n_cmp++;
        if (CounterValue !== 16'h0003) begin
            n_err++; $display("FAIL offset_pos_wrap: got %h want 0003", CounterValue);
        end
        cycle(0, 0, 1, 16'hFFFF, 0, '0, 0, 0, '0);
        idle();
        n_cmp++;
        if (CounterValue !== 16'h0000) begin
            n_err++; $display("FAIL inc_wrap: got %h want 0000", CounterValue);
        end
        n_cmp++;
        if (StackUnderflow !== FLAGS_EN) begin
            n_err++; $display("FAIL underflow_sticky: got %b want %b", StackUnderflow, FLAGS_EN);
        end
    endtask

    task automatic test_priority();
        cycle(1, 0, 0, '0, 0, '0, 0, 0, '0);
        cycle(0, 0, 0, '0, 1, 16'h0300, 0, 0, '0);
        cycle(0, 0, 1, 16'h1234, 1, 16'h0777, 1, 1, 9'h005);
        n_cmp++;
        if (CounterValue !== 16'h1234 || StackCount !== 4'd1) begin
            n_err++; $display("FAIL load_priority: got pc %h cnt %0d want pc 1234 cnt 1", CounterValue, StackCount);
        end
        cycle(0, 1, 0, '0, 1, 16'h0777, 0, 0, '0);
        n_cmp++;
        if (CounterValue !== 16'h1234 || StackCount !== 4'd1) begin
            n_err++; $display("FAIL stall_call: got pc %h cnt %0d want pc 1234 cnt 1", CounterValue, StackCount);
        end
        cycle(0, 0, 0, '0, 0, '0, 1, 1, 9'h010);
        n_cmp++;
        if (CounterValue !== 16'h0001 || StackCount !== 4'd0) begin
            n_err++; $display("FAIL ret_over_offset: got pc %h cnt %0d want pc 0001 cnt 0", CounterValue, StackCount);
        end
    endtask

    task automatic test_reset_override();
        cycle(1, 0, 0, '0, 0, '0, 0, 0, '0);
        cycle(0, 0, 0, '0, 0, '0, 1, 0, '0);
        for (int i = 0; i < 3; i++)
            cycle(0, 0, 0, '0, 1, 16'h0400 + 16'(i), 0, 0, '0);
        n_cmp++;
        if (StackCount !== 4'd3 || StackUnderflow !== FLAGS_EN) begin
            n_err++; $display("FAIL pre_reset: got cnt %0d unf %b want cnt 3 unf %b", StackCount, StackUnderflow, FLAGS_EN);
        end
        cycle(1, 1, 0, '0, 1, 16'h0999, 0, 0, '0);
        n_cmp++;
        if (CounterValue !== 16'h0000 || StackCount !== 4'd0 ||
            {StackOverflow, StackUnderflow} !== 2'b00) begin
            n_err++;
            $display("FAIL reset_override: got pc %h cnt %0d flags %b want pc 0000 cnt 0 flags 00", CounterValue, StackCount, {StackOverflow, StackUnderflow});
        end
    endtask

    task automatic test_random();
        bit rst, stall, ld, call, ret, off_en;
        cycle(1, 0, 0, '0, 0, '0, 0, 0, '0);
        for (int i = 0; i < 600; i++) begin
            rst    = ($urandom_range(0, 79) == 0);
            stall  = ($urandom_range(0, 7) == 0);
            ld     = ($urandom_range(0, 11) == 0);
            call   = ($urandom_range(0, 2) == 0);
            ret    = ($urandom_range(0, 2) == 0);
            off_en = ($urandom_range(0, 3) == 0);
            cycle(rst, stall, ld, 16'($urandom), call, 16'($urandom), ret, off_en, 9'($urandom));
            n_cmp++;
            if (CounterValue !== m_pc || StackCount !== 4'(m_stack.size()) ||
                StackOverflow !== (FLAGS_EN & m_ovf) ||
                StackUnderflow !== (FLAGS_EN & m_unf)) begin
                n_err++;
                $display("FAIL random[%0d]: got pc %h cnt %0d ovf %b unf %b want pc %h cnt %0d ovf %b unf %b", i, CounterValue, StackCount, StackOverflow, StackUnderflow, m_pc, m_stack.size(), FLAGS_EN & m_ovf, FLAGS_EN & m_unf);
            end
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_increment();
        test_call_return();
        test_overflow();
        test_underflow_offset_wrap();
        test_priority();
        test_reset_override();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
